// File: rtl/prm_ctrl_arb_if.sv
// Engine handshake between the parameter controller (master) and the hash engine (slave).
interface prm_ctrl_arb_if #(
  parameter int unsigned MODE_W = 2,
  parameter int unsigned SLOT_W = 2
);
  logic              eng_req;
  logic [SLOT_W-1:0] eng_slot;
  logic [MODE_W-1:0] eng_mode;
  logic              eng_ack;
  logic              eng_done;
  logic              eng_abort;

  modport master (
    output eng_req, eng_slot, eng_mode, eng_abort,
    input  eng_ack, eng_done
  );

  modport slave (
    input  eng_req, eng_slot, eng_mode, eng_abort,
    output eng_ack, eng_done
  );
endinterface

// File: rtl/prm_ctrl_arb.sv
// NSLOT parameter slots with per-slot expiry, handed to the hash engine one at a
// time through a round-robin req/ack/done handshake.
module prm_ctrl_arb #(
  parameter int unsigned NSLOT  = 4,
  parameter int unsigned MODE_W = 2,
  parameter int unsigned TMO    = 255,
  parameter int unsigned SLOT_W = $clog2(NSLOT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_hash,
  input  logic [MODE_W-1:0]       mode_in,
  input  logic [NSLOT-1:0]        prm_set,
  input  logic [NSLOT-1:0]        prm_clr,
  output logic [NSLOT-1:0]        prm_vld,
  output logic [NSLOT-1:0]        prm_busy,
  output logic [NSLOT*MODE_W-1:0] prm_mode,
  output logic [NSLOT-1:0]        tmo_pulse,
  prm_ctrl_arb_if.master          eng
);

  localparam int unsigned AGE_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((TMO == 0) ? 0 : TMO - 1);

  // Encoding chosen so prm_vld/prm_busy are single flop bits of the state.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_VALID = 2'b01,
    S_BUSY  = 2'b11
  } slot_st_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_REQ,
    A_RUN
  } arb_st_t;

  slot_st_t          st  [NSLOT];
  logic [AGE_W-1:0]  age [NSLOT];
  arb_st_t           a_st;
  logic [SLOT_W-1:0] rr;

  logic [NSLOT-1:0]  offered;
  logic [NSLOT-1:0]  expire;
  logic [NSLOT-1:0]  eligible;
  logic              found;
  logic [SLOT_W-1:0] sel;
  logic [MODE_W-1:0] sel_mode;

  always_comb begin
    for (int unsigned i = 0; i < NSLOT; i++) begin
      prm_vld[i]  = st[i][0];
      prm_busy[i] = st[i][1];
      offered[i]  = (a_st == A_REQ) && (eng.eng_slot == SLOT_W'(i));
      expire[i]   = (TMO != 0) && (st[i] == S_VALID) && !offered[i] && (age[i] == AGE_LAST);
      // Only slots still VALID after this edge may be picked, so an offer never
      // points at a slot that is being cleared or expiring right now.
      eligible[i] = (st[i] == S_VALID) && !clr_hash && !prm_clr[i] && !expire[i];
    end
  end

  always_comb begin
    int unsigned idx;
    logic [SLOT_W-1:0] j;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    j     = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      idx = 32'(rr) + k;
      if (idx >= NSLOT) idx = idx - NSLOT;
      j = SLOT_W'(idx);
      if (!found && eligible[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
    // A same-cycle re-set recaptures the slot mode; offer the new value.
    sel_mode = prm_set[sel] ? mode_in : prm_mode[sel*MODE_W +: MODE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= '{default: S_IDLE};
      age       <= '{default: '0};
      prm_mode  <= '0;
      tmo_pulse <= '0;
    end else begin
      tmo_pulse <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        if (clr_hash) begin
          st[i]                     <= S_IDLE;
          age[i]                    <= '0;
          prm_mode[i*MODE_W +: MODE_W] <= '0;
        end else begin
          case (st[i])
            S_IDLE: begin
              if (prm_set[i] && !prm_clr[i]) begin
                st[i]                        <= S_VALID;
                age[i]                       <= '0;
                prm_mode[i*MODE_W +: MODE_W] <= mode_in;
              end
            end
            S_VALID: begin
              if (prm_clr[i]) begin
                st[i]                        <= S_IDLE;
                age[i]                       <= '0;
                prm_mode[i*MODE_W +: MODE_W] <= '0;
              end else if (offered[i]) begin
                if (eng.eng_ack) st[i] <= S_BUSY;
              end else if (expire[i]) begin
                st[i]                        <= S_IDLE;
                age[i]                       <= '0;
                prm_mode[i*MODE_W +: MODE_W] <= '0;
                tmo_pulse[i]                 <= 1'b1;
              end else if (prm_set[i]) begin
                age[i]                       <= '0;
                prm_mode[i*MODE_W +: MODE_W] <= mode_in;
              end else begin
                age[i] <= age[i] + 1'b1;
              end
            end
            S_BUSY: begin
              // Only the running slot can be BUSY, and only while the arbiter runs it.
              if (eng.eng_done) begin
                st[i]                        <= S_IDLE;
                age[i]                       <= '0;
                prm_mode[i*MODE_W +: MODE_W] <= '0;
              end
            end
            default: st[i] <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_st          <= A_IDLE;
      rr            <= '0;
      eng.eng_req   <= 1'b0;
      eng.eng_slot  <= '0;
      eng.eng_mode  <= '0;
      eng.eng_abort <= 1'b0;
    end else begin
      eng.eng_abort <= 1'b0;
      case (a_st)
        A_IDLE: begin
          if (found) begin
            a_st         <= A_REQ;
            eng.eng_req  <= 1'b1;
            eng.eng_slot <= sel;
            eng.eng_mode <= sel_mode;
          end
        end
        A_REQ: begin
          if (clr_hash || prm_clr[eng.eng_slot]) begin
            a_st        <= A_IDLE;
            eng.eng_req <= 1'b0;
          end else if (eng.eng_ack) begin
            a_st        <= A_RUN;
            eng.eng_req <= 1'b0;
            rr          <= (eng.eng_slot == SLOT_W'(NSLOT - 1)) ? '0 : eng.eng_slot + 1'b1;
          end
        end
        A_RUN: begin
          if (clr_hash) begin
            a_st          <= A_IDLE;
            eng.eng_abort <= 1'b1;
          end else if (eng.eng_done) begin
            a_st <= A_IDLE;
          end
        end
        default: a_st <= A_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prm_ctrl_arb.md
Name: prm_ctrl_arb

Overview:
- Parametrised successor of the two-slot hash parameter controller.
- Holds NSLOT parameter slots. Each slot has a valid flag and a MODE_W-bit mode, captured from mode_in on set; mode generalises the old 384-bit flag.
- Adds a per-slot expiry timer and a round-robin req/ack/done handshake that hands valid slots to the hash engine one at a time.
- Sits between the SPI command decoder (set/clr strobes) and the hash engine.

Parameters:
NSLOT, 4, number of parameter slots (2..16)
MODE_W, 2, width of per-slot mode field (1 = legacy 384 flag)
TMO, 255, cycles a VALID slot may wait unserved before auto-expiry; 0 disables expiry
SLOT_W, $clog2(NSLOT), slot index width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clr_hash  in  1  global clear; highest priority
mode_in  in  MODE_W  mode captured on any accepted set
prm_set  in  NSLOT  per-slot set strobe
prm_clr  in  NSLOT  per-slot clear strobe
prm_vld  out  NSLOT  slot state is VALID or BUSY
prm_busy  out  NSLOT  slot state is BUSY
prm_mode  out  NSLOT*MODE_W  captured mode; slot i at [i*MODE_W +: MODE_W]
tmo_pulse  out  NSLOT  1-cycle pulse when slot expires
eng_req  out  1  slot offered to engine
eng_slot  out  SLOT_W  offered/running slot index
eng_mode  out  MODE_W  mode of offered/running slot
eng_ack  in  1  engine accepts offer
eng_done  in  1  engine finished running slot
eng_abort  out  1  1-cycle pulse: running job killed by clr_hash

Behaviour:
- Reset (async, rst=1): all slots IDLE, modes 0, ages 0; all outputs 0; arbiter IDLE; rr pointer 0.
- All outputs are registered. prm_set at cycle t gives prm_vld=1 at t+1. The earliest resulting eng_req is at t+2.

Slot FSM (per slot), priority clr_hash > prm_clr > done/ack > timeout > prm_set:
- IDLE: set -> VALID; mode<=mode_in; age<=0.
- VALID (not offered): clr -> IDLE, mode<=0. set -> stay VALID, mode re-captured, age<=0. Otherwise age++. If TMO!=0 and age==TMO-1 -> IDLE, mode<=0, tmo_pulse=1 next cycle.
- VALID (offered): age frozen, no expiry; set ignored. clr -> IDLE and offer withdrawn. ack -> BUSY.
- BUSY: set and per-slot clr ignored. eng_done -> IDLE, mode<=0.
- clr_hash: every slot -> IDLE, mode 0, age 0, in any state.

Arbiter FSM:
- A_IDLE: if any slot is VALID, select the first VALID slot at or after rr pointer (wrapping modulo NSLOT). Register eng_slot and eng_mode, go A_REQ. eng_req=1 from the next cycle.
- A_REQ: eng_req, eng_slot and eng_mode held stable until eng_ack.
  - eng_ack -> A_RUN; eng_req<=0; rr pointer <= eng_slot+1 (wrap).
  - Offered slot cleared, or clr_hash -> eng_req<=0, A_IDLE; pointer unchanged.
- A_RUN: eng_slot and eng_mode held.
  - eng_done -> A_IDLE.
  - clr_hash -> A_IDLE; eng_abort=1 for one cycle.
- Ignored inputs: eng_ack outside A_REQ; eng_done outside A_RUN.
- Same-cycle eng_ack and clr_hash: clr_hash wins. No BUSY state, no abort.

Test Plan:
- Reset/basic (NSLOT=4, MODE_W=2): set slot 2 with mode_in=2'b11 at t -> prm_vld=4'b0100 at t+1, prm_mode[5:4]=3; eng_req=1 with eng_slot=2, eng_mode=3 at t+2; ack -> prm_busy=4'b0100; eng_done -> prm_vld=0.
- Round robin: slots 0,1,3 VALID, pointer 0 -> grants in order 0,1,3. Then set 0 and 3 together while pointer=0 -> 0 first, then 3.
- Expiry (TMO=8): set slot 1, engine held busy on slot 0 -> tmo_pulse[1] exactly 8 cycles after prm_vld[1] rose; prm_vld[1]=0 the same cycle. Re-set at cycle 5 restarts the count.
- Withdraw: slot 3 offered, prm_clr[3] before ack -> eng_req drops next cycle; arbiter re-offers the next VALID slot; ack never completed.
- Abort: slot 0 BUSY, clr_hash=1 -> all prm_vld/prm_busy=0, eng_abort pulses once. A later eng_done is ignored; prm_set and prm_clr on the same slot in the same cycle -> IDLE.
- Async reset mid-A_RUN: rst asserted between clock edges -> all outputs 0 immediately; state after deassertion matches power-on.
